// File: rtl/hilo_mac_ctrl.sv
// ============================================================================
// Module   : hilo_mac_ctrl
// Purpose  : Multi-cycle shift-add multiply/accumulate sequencer owning HI/LO.
//            Optional macro HILO_MT_EN adds mthi (40) / mtlo (41) moves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_mac_ctrl #(
  parameter int BPC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int N = 32 / BPC;
  localparam logic [5:0] c_CNT_LAST = 6'(N - 1);
  localparam logic [5:0] c_OP_MUL   = 6'd39;
  localparam logic [5:0] c_OP_MADD  = 6'd6;
  localparam logic [5:0] c_OP_MADDU = 6'd7;
  localparam logic [5:0] c_OP_MTHI  = 6'd40;
  localparam logic [5:0] c_OP_MTLO  = 6'd41;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_is_mul;
  logic        r_neg;
  logic        r_err;
  logic [5:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mult;
  logic        w_signed;
  logic        w_legal;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_digit;
  logic [63:0] w_pp;
  logic [63:0] w_p;
  logic [63:0] w_result;

  assign w_signed  = (req_op == c_OP_MUL) || (req_op == c_OP_MADD);
  assign w_is_mult = w_signed || (req_op == c_OP_MADDU);
`ifdef HILO_MT_EN
  assign w_legal   = w_is_mult || (req_op == c_OP_MTHI) || (req_op == c_OP_MTLO);
`else
  assign w_legal   = w_is_mult;
`endif

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a = (w_signed && req_a[31]) ? (~req_a + 32'd1) : req_a;
  assign w_mag_b = (w_signed && req_b[31]) ? (~req_b + 32'd1) : req_b;

  assign w_digit  = 64'(r_mplier[BPC-1:0]);
  assign w_pp     = r_mcand * w_digit;
  assign w_p      = r_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_result = r_is_mul ? w_p : ({r_hi, r_lo} + w_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_next = w_is_mult ? S_RUN : S_RESP;
        end
      end
      S_RUN: begin
        if (r_cnt == c_CNT_LAST) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        done   = ~r_err;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_mul <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 6'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_err <= ~w_legal;
            if (w_is_mult) begin
              r_is_mul <= (req_op == c_OP_MUL);
              r_neg    <= w_signed & (req_a[31] ^ req_b[31]);
              r_mcand  <= {32'd0, w_mag_a};
              r_mplier <= w_mag_b;
              r_acc    <= 64'd0;
              r_cnt    <= 6'd0;
            end
`ifdef HILO_MT_EN
            if (req_op == c_OP_MTHI) begin
              r_hi <= req_a;
            end
            if (req_op == c_OP_MTLO) begin
              r_lo <= req_a;
            end
`endif
          end
        end
        S_RUN: begin
          // Shifting the multiplicand each step equals mcand << (count*BPC).
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << BPC;
          r_mplier <= r_mplier >> BPC;
          r_cnt    <= r_cnt + 6'd1;
        end
        S_FIN: begin
          r_hi <= w_result[63:32];
          r_lo <= w_result[31:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mac_ctrl.sv
// ============================================================================
// Module   : tb_hilo_mac_ctrl
// Purpose  : Directed self-checking bench for hilo_mac_ctrl (BPC = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_mac_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  hilo_mac_ctrl #(.BPC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request from a negedge; returns at the negedge of the response
  // cycle. lat counts cycles after the acceptance edge (0 = cycle right after).
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0BAD_F00D;
    req_op    = 6'd39;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (done || err) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL response_timeout op=%0d got no done/err within 40 cycles", op);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h_%h exp 0_0", hi, lo);
    end
    checks++;
    if ({done, err, busy, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl got done/err/busy/ready=%b exp 0001", {done, err, busy, req_ready});
    end
  endtask

  task automatic test_mul_latency();
    int lat;
    req_valid = 1'b1;
    req_op    = 6'd39;
    req_a     = 32'hFFFF_FFFD;
    req_b     = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 32'h1111_1111;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept got ready=%b busy=%b exp 0 1", req_ready, busy);
    end
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (done || err) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL mul_latency got %0d exp 9", lat);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || err !== 1'b0) begin
      errors++;
      $display("FAIL mul_neg got %h_%h err=%b exp ffffffff_fffffff1 err=0", hi, lo, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_resp got done=%b ready=%b busy=%b exp 0 1 0", done, req_ready, busy);
    end
  endtask

  task automatic test_maddu();
    int lat;
    pulse_reset();
    issue(6'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || done !== 1'b1) begin
      errors++;
      $display("FAIL maddu_1 got %h_%h done=%b exp fffffffe_00000001 1", hi, lo, done);
    end
    @(negedge clk);
    issue(6'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    // 2*(2^64 - 2^33 + 1) mod 2^64 = 0xFFFFFFFC_00000002
    checks++;
    if (hi !== 32'hFFFF_FFFC || lo !== 32'h0000_0002) begin
      errors++;
      $display("FAIL maddu_2 got %h_%h exp fffffffc_00000002", hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_signed_edge();
    int lat;
    issue(6'd39, 32'h8000_0000, 32'h8000_0000, lat);
    checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
      errors++;
      $display("FAIL mul_min got %h_%h exp 40000000_00000000", hi, lo);
    end
    @(negedge clk);
    issue(6'd6, 32'hFFFF_FFFF, 32'd1, lat);
    checks++;
    if (hi !== 32'h3FFF_FFFF || lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL madd_neg got %h_%h exp 3fffffff_ffffffff", hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_valid();
    int accepts;
    int dones;
    accepts   = 0;
    dones     = 0;
    req_valid = 1'b1;
    req_op    = 6'd39;
    req_a     = 32'd2;
    req_b     = 32'd3;
    for (int c = 0; c < 11; c++) begin
      if (req_ready && req_valid) accepts++;
      if (done) dones++;
      @(negedge clk);
      req_a = 32'd7;
    end
    req_valid = 1'b0;
    checks++;
    if (accepts != 1 || dones != 1) begin
      errors++;
      $display("FAIL hold_accepts got accepts=%0d dones=%0d exp 1 1", accepts, dones);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL hold_capture got %h_%h exp 00000000_00000006", hi, lo);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue(6'h2A, 32'h5555_5555, 32'h1, lat);
    checks++;
    if (lat != 0 || err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err got lat=%0d err=%b done=%b exp 0 1 0", lat, err, done);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL illegal_hilo got %h_%h exp 00000000_00000006", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_after got err=%b ready=%b exp 0 1", err, req_ready);
    end
  endtask

  task automatic test_move();
    int lat;
    issue(6'd40, 32'h0000_1234, 32'd0, lat);
`ifdef HILO_MT_EN
    checks++;
    if (lat != 0 || done !== 1'b1 || err !== 1'b0 || hi !== 32'h1234 || lo !== 32'd6) begin
      errors++;
      $display("FAIL mthi got lat=%0d done=%b err=%b %h_%h exp 0 1 0 00001234_00000006",
               lat, done, err, hi, lo);
    end
`else
    checks++;
    if (lat != 0 || err !== 1'b1 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL mthi_illegal got lat=%0d done=%b err=%b %h_%h exp 0 0 1 00000000_00000006",
               lat, done, err, hi, lo);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones     = 0;
    req_valid = 1'b1;
    req_op    = 6'd39;
    req_a     = 32'd5;
    req_b     = 32'd6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got %h_%h busy=%b done=%b exp 0_0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready got %b exp 1", req_ready);
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done || err) dones++;
    end
    checks++;
    if (dones != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_nodone got pulses=%0d %h_%h exp 0 0_0", dones, hi, lo);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 6'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_mul_latency();
    test_maddu();
    test_signed_edge();
    test_hold_valid();
    test_illegal();
    test_move();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
